alu_issue_ctrl: RTL

Initiator side of the ALU interface. It accepts one operation request via a valid/ready handshake, registers the operands and 4-bit ALU control code to the ALU, and captures the ALU result and flags one cycle later. It then presents them on a held response handshake and keeps the architectural flag register. It sits between the decode/operand-read stage and the writeback stage of the miniRISC datapath.

---
 rtl/alu_ctrl_pkg.sv | 28 ++
 rtl/alu_operand_mux.sv | 39 +++
 rtl/alu_issue_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control codes, flag bit positions and issue-controller state encoding.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_SUM   = 4'd0;
    localparam logic [3:0] ALU_COMP  = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_XOR   = 4'd3;
    localparam logic [3:0] ALU_DIFF  = 4'd4;
    localparam logic [3:0] ALU_SHR   = 4'd5;
    localparam logic [3:0] ALU_SHL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_FLAGS = 4'd8;

    localparam int FLAG_SIGN  = 2;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_CARRY = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } issue_state_t;

    function automatic logic is_shift(input logic [3:0] code);
        return (code == ALU_SHR) || (code == ALU_SHL) || (code == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_operand_mux.sv
// Operand-b select and code forwarding for the ALU drive registers.
// Build option SHIFT_CLAMP_EN: shift codes see only b[4:0] (amount mod 32).
module alu_operand_mux
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        funct,
    input  logic              imm_sel,
    input  logic [DATA_W-1:0] rt,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] b,
    output logic [3:0]        ctrl
);

    logic [DATA_W-1:0] b_raw_s;

    // Select operand b, optionally clamping shift amounts.
    always_comb begin
        b_raw_s = {DATA_W{1'b0}};
        b       = {DATA_W{1'b0}};
        if (imm_sel) begin
            b_raw_s = imm;
        end else begin
            b_raw_s = rt;
        end
`ifdef SHIFT_CLAMP_EN
        if (is_shift(funct)) begin
            b = {{(DATA_W-5){1'b0}}, b_raw_s[4:0]};
        end else begin
            b = b_raw_s;
        end
`else
        b = b_raw_s;
`endif
        ctrl = funct;
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU initiator: accepts one request, drives the ALU for one cycle, captures and
// holds the response, and keeps the flag register. Build option: SHIFT_CLAMP_EN.
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_funct,
    input  logic              req_imm_sel,
    input  logic [DATA_W-1:0] req_rs,
    input  logic [DATA_W-1:0] req_rt,
    input  logic [DATA_W-1:0] req_imm,
    input  logic [REG_AW-1:0] req_rd,
    input  logic              req_set_flags,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [2:0]        alu_flag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [REG_AW-1:0] rsp_rd,
    output logic [2:0]        rsp_flag,
    output logic [2:0]        flag_reg,
    output logic              busy
);

    issue_state_t      state_r;
    logic [REG_AW-1:0] rd_r;
    logic              set_flags_r;
    logic [DATA_W-1:0] b_mux_s;
    logic [3:0]        ctrl_mux_s;

    alu_operand_mux #(.DATA_W(DATA_W)) u_operand_mux (
        .funct   (req_funct),
        .imm_sel (req_imm_sel),
        .rt      (req_rt),
        .imm     (req_imm),
        .b       (b_mux_s),
        .ctrl    (ctrl_mux_s)
    );

    // Handshake status is a pure decode of the state register.
    always_comb begin
        req_ready = (state_r == IDLE);
        busy      = (state_r != IDLE);
    end

    // Issue FSM with ALU drive, response capture and flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            alu_a       <= {DATA_W{1'b0}};
            alu_b       <= {DATA_W{1'b0}};
            alu_ctrl    <= 4'd0;
            rd_r        <= {REG_AW{1'b0}};
            set_flags_r <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_result  <= {DATA_W{1'b0}};
            rsp_rd      <= {REG_AW{1'b0}};
            rsp_flag    <= 3'd0;
            flag_reg    <= 3'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        alu_a       <= req_rs;
                        alu_b       <= b_mux_s;
                        alu_ctrl    <= ctrl_mux_s;
                        rd_r        <= req_rd;
                        set_flags_r <= req_set_flags;
                        state_r     <= ISSUE;
                    end
                end
                // ALU output has settled from the registered drive; capture it.
                ISSUE: begin
                    rsp_result <= alu_result;
                    rsp_flag   <= alu_flag;
                    rsp_rd     <= rd_r;
                    rsp_valid  <= 1'b1;
                    if (set_flags_r) begin
                        flag_reg <= alu_flag;
                    end
                    state_r <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule
